// File: rtl/frame_writer.sv
// frame_writer
//   Write-side agent for the 160x120 1-bit background frame buffer.
//   Accepts single-pixel write requests over valid/ready and bounds-checks
//   them. Legal requests become one RAM write at x + y*H_PIXELS in the next
//   cycle. Out-of-range requests are dropped, and drop_pulse flags each one.
//   An optional fill engine sweeps the whole buffer with a constant value.
//
//   Build option: FRAME_WRITER_FILL_EN enables the fill engine.
//   Without it, fill_start and fill_data are ignored, busy is 0, and
//   req_ready is always 1.
//
//   Ports
//     clk          system clock, all state on posedge
//     resetn       asynchronous active-low reset
//     req_valid    pixel write request present
//     req_ready    request accepted when high together with req_valid
//     req_x/req_y  pixel column / row (8 bit)
//     req_data     pixel value
//     fill_start   start full-buffer fill (level-sampled in IDLE)
//     fill_data    fill value, sampled with fill_start
//     busy         fill in progress
//     drop_pulse   one-cycle pulse for an accepted out-of-range request
//     ram_address  RAM write address
//     ram_data     RAM write data
//     ram_wren     RAM write enable
//
//   state | meaning
//   IDLE  | accepting pixel requests, watching fill_start
//   FILL  | writing the fill value to every address, requests blocked
module frame_writer #(
    parameter int H_PIXELS = 160,
    parameter int V_PIXELS = 120,
    parameter int ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [7:0]        req_x,
    input  logic [7:0]        req_y,
    input  logic              req_data,
    input  logic              fill_start,
    input  logic              fill_data,
    output logic              busy,
    output logic              drop_pulse,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_data,
    output logic              ram_wren
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIXELS * V_PIXELS - 1);

    logic [ADDR_W-1:0] r_ram_address;
    logic              r_ram_data;
    logic              r_ram_wren;
    logic              r_drop_pulse;

    logic              w_req_ready;
    logic              w_busy;
    logic              w_fill_entry;
    logic              w_filling;
    logic              w_accept;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_x_ext;
    logic [ADDR_W-1:0] w_y_ext;
    logic [ADDR_W-1:0] w_pix_addr;

`ifdef FRAME_WRITER_FILL_EN
    typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

    state_t r_state;
    state_t w_state_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The fill uses ram_address as its counter. The state leaves FILL
    // while the last address is being written.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (fill_start) w_state_nxt = S_FILL;
            S_FILL:  if (r_ram_address == LAST_ADDR) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_req_ready  = (r_state == S_IDLE) && !fill_start;
        w_busy       = (r_state == S_FILL);
        w_fill_entry = (r_state == S_IDLE) && fill_start;
        w_filling    = (r_state == S_FILL) && (r_ram_address != LAST_ADDR);
    end
`else
    logic w_unused;
    assign w_unused     = ^{fill_start, fill_data};
    assign w_req_ready  = 1'b1;
    assign w_busy       = 1'b0;
    assign w_fill_entry = 1'b0;
    assign w_filling    = 1'b0;
`endif

    assign w_accept   = req_valid && w_req_ready;
    assign w_x_ext    = ADDR_W'(req_x);
    assign w_y_ext    = ADDR_W'(req_y);
    assign w_in_range = (w_x_ext < ADDR_W'(H_PIXELS)) && (w_y_ext < ADDR_W'(V_PIXELS));
    // Product is formed at ADDR_W bits so the corner pixel (19199) is not clipped.
    assign w_pix_addr = w_y_ext * ADDR_W'(H_PIXELS) + w_x_ext;

    // The fill writes address 0 on the edge that enters FILL, so each FILL
    // cycle presents one write and the sweep ends with the last address.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ram_address <= '0;
            r_ram_data    <= 1'b0;
            r_ram_wren    <= 1'b0;
            r_drop_pulse  <= 1'b0;
        end else begin
            r_ram_wren   <= 1'b0;
            r_drop_pulse <= 1'b0;
            if (w_fill_entry) begin
                r_ram_address <= '0;
                r_ram_data    <= fill_data;
                r_ram_wren    <= 1'b1;
            end else if (w_filling) begin
                r_ram_address <= r_ram_address + 1'b1;
                r_ram_wren    <= 1'b1;
            end else if (w_accept) begin
                if (w_in_range) begin
                    r_ram_address <= w_pix_addr;
                    r_ram_data    <= req_data;
                    r_ram_wren    <= 1'b1;
                end else begin
                    r_drop_pulse <= 1'b1;
                end
            end
        end
    end

    assign req_ready   = w_req_ready;
    assign busy        = w_busy;
    assign drop_pulse  = r_drop_pulse;
    assign ram_address = r_ram_address;
    assign ram_data    = r_ram_data;
    assign ram_wren    = r_ram_wren;

endmodule

// File: tb/tb_frame_writer.sv
module tb_frame_writer;

    localparam int H  = 160;
    localparam int V  = 120;
    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_data = 1'b0;
    logic          fill_start = 1'b0;
    logic          fill_data = 1'b0;
    logic [7:0]    req_x = 8'd0;
    logic [7:0]    req_y = 8'd0;
    logic          req_ready;
    logic          busy;
    logic          drop_pulse;
    logic          ram_data;
    logic          ram_wren;
    logic [AW-1:0] ram_address;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    frame_writer #(.H_PIXELS(H), .V_PIXELS(V), .ADDR_W(AW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_data    (req_data),
        .fill_start  (fill_start),
        .fill_data   (fill_data),
        .busy        (busy),
        .drop_pulse  (drop_pulse),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic ew, input logic ed,
                              input int ea, input logic edat);
        check({tag, "_wren"}, 32'(ram_wren), 32'(ew));
        check({tag, "_drop"}, 32'(drop_pulse), 32'(ed));
        check({tag, "_addr"}, 32'(ram_address), 32'(ea));
        check({tag, "_data"}, 32'(ram_data), 32'(edat));
    endtask

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       d;
        logic       wren;
        logic       drop;
        int         addr;
        logic       data;
    } vec_t;

    vec_t vecs[9];

    int   m_addr;
    logic m_data;
    logic v, d, inr, ew, ed;
    int   x, y;
    int   idx, bad, wait_cnt;

    initial begin
        vecs[0] = '{8'd0,   8'd0,   1'b1, 1'b1, 1'b0, 0,     1'b1};
        vecs[1] = '{8'd159, 8'd119, 1'b0, 1'b1, 1'b0, 19199, 1'b0};
        vecs[2] = '{8'd10,  8'd1,   1'b1, 1'b1, 1'b0, 170,   1'b1};
        vecs[3] = '{8'd11,  8'd1,   1'b0, 1'b1, 1'b0, 171,   1'b0};
        vecs[4] = '{8'd12,  8'd1,   1'b1, 1'b1, 1'b0, 172,   1'b1};
        vecs[5] = '{8'd160, 8'd0,   1'b1, 1'b0, 1'b1, 172,   1'b1};
        vecs[6] = '{8'd0,   8'd120, 1'b1, 1'b0, 1'b1, 172,   1'b1};
        vecs[7] = '{8'd255, 8'd255, 1'b1, 1'b0, 1'b1, 172,   1'b1};
        vecs[8] = '{8'd5,   8'd3,   1'b0, 1'b1, 1'b0, 485,   1'b0};

        // Reset state
        #12;
        check("rst_ready", 32'(req_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check_outs("rst", 1'b0, 1'b0, 0, 1'b0);
        #1 resetn = 1'b1;
        step();

        // Table: back-to-back requests, one per cycle
        for (int i = 0; i < 9; i++) begin
            req_valid = 1'b1;
            req_x     = vecs[i].x;
            req_y     = vecs[i].y;
            req_data  = vecs[i].d;
            #1;
            check("tbl_ready", 32'(req_ready), 1);
            step();
            check_outs($sformatf("tbl%0d", i), vecs[i].wren, vecs[i].drop,
                       vecs[i].addr, vecs[i].data);
        end
        req_valid = 1'b0;
        step();
        check_outs("tbl_idle", 1'b0, 1'b0, vecs[8].addr, vecs[8].data);

        // Randomized requests against a reference model
        m_addr = vecs[8].addr;
        m_data = vecs[8].data;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            x = $urandom_range(0, 200);
            y = $urandom_range(0, 140);
            d = 1'($urandom_range(0, 1));
            req_valid = v;
            req_x     = 8'(x);
            req_y     = 8'(y);
            req_data  = d;
            #1;
            check("rnd_ready", 32'(req_ready), 1);
            step();
            inr = (x < H) && (y < V);
            ew  = v && inr;
            ed  = v && !inr;
            if (ew) begin
                m_addr = y * H + x;
                m_data = d;
            end
            check_outs("rnd", ew, ed, m_addr, m_data);
        end
        req_valid = 1'b0;
        step();

`ifdef FRAME_WRITER_FILL_EN
        // Fill start with a concurrent request: request waits for the fill
        fill_start = 1'b1;
        fill_data  = 1'b1;
        req_valid  = 1'b1;
        req_x      = 8'd7;
        req_y      = 8'd2;
        req_data   = 1'b1;
        #1;
        check("fill_start_ready", 32'(req_ready), 0);
        step();
        fill_start = 1'b0;
        fill_data  = 1'b0;
        idx = 0;
        bad = 0;
        while (busy && idx < 20000) begin
            if (!(ram_wren && ram_address == AW'(idx) && ram_data)) bad++;
            if (req_ready) bad++;
            idx++;
            step();
        end
        check("fill_len", 32'(idx), 19200);
        check("fill_bad_cycles", 32'(bad), 0);
        check("fill_done_ready", 32'(req_ready), 1);
        check("fill_done_wren", 32'(ram_wren), 0);
        step();
        req_valid = 1'b0;
        check_outs("fill_pending_req", 1'b1, 1'b0, 2 * H + 7, 1'b1);
        step();

        // Reset in the middle of a fill
        fill_start = 1'b1;
        fill_data  = 1'b1;
        step();
        fill_start = 1'b0;
        wait_cnt = 0;
        while (32'(ram_address) != 5000 && wait_cnt < 6000) begin
            step();
            wait_cnt++;
        end
        check("midfill_reach", 32'(ram_address), 5000);
        #2 resetn = 1'b0;
        #1;
        check("midfill_rst_busy", 32'(busy), 0);
        check_outs("midfill_rst", 1'b0, 1'b0, 0, 1'b0);
        #2 resetn = 1'b1;
        step();
        check("midfill_post_busy", 32'(busy), 0);
        check("midfill_post_ready", 32'(req_ready), 1);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (ram_wren || busy) bad++;
            step();
        end
        check("midfill_no_resume", 32'(bad), 0);
`else
        // Fill disabled: fill_start is ignored, concurrent request goes through
        fill_start = 1'b1;
        fill_data  = 1'b1;
        req_valid  = 1'b1;
        req_x      = 8'd20;
        req_y      = 8'd4;
        req_data   = 1'b0;
        #1;
        check("nofill_ready", 32'(req_ready), 1);
        step();
        req_valid = 1'b0;
        check("nofill_busy", 32'(busy), 0);
        check_outs("nofill_req", 1'b1, 1'b0, 4 * H + 20, 1'b0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ram_wren || busy || !req_ready) bad++;
        end
        check("nofill_no_writes", 32'(bad), 0);
        fill_start = 1'b0;
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
